// File: rtl/mdu_iterative_if.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iterative_if
//  Purpose  : Issue/result bundle between the issuing stage and the iterative
//             RV32M multiply/divide unit. The result side feeds the register
//             file write port (result -> wd3, wa -> wa3, we -> we3).
//  Revision : 1.0  initial release
// ============================================================================
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  // Request side, driven by the issuing stage
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;

  // Response side, driven by the unit
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      wa;
  logic            we;

  // Issuing stage view
  modport master (
    output start, flush, funct3, a, b, rd,
    input  busy, done, result, wa, we
  );

  // Multiply/divide unit view
  modport slave (
    input  start, flush, funct3, a, b, rd,
    output busy, done, result, wa, we
  );
endinterface
`default_nettype wire

// File: rtl/mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_iterative
//  Purpose  : Iterative RV32M multiply/divide unit. Captures operand
//             magnitudes on accept, runs 32 shift-add (multiply) or restoring
//             (divide) iterations, then presents a registered result with a
//             one-cycle done / register-file write enable.
//  Revision : 1.0  initial release
// ============================================================================
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  mdu_iterative_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter value during the final (32nd) iteration
  localparam logic [5:0] C_LAST_ITER = 6'(XLEN - 1);

  localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] C_ALL_ONES = {XLEN{1'b1}};

  localparam logic [2:0] C_MUL    = 3'b000;
  localparam logic [2:0] C_MULH   = 3'b001;
  localparam logic [2:0] C_MULHSU = 3'b010;
  localparam logic [2:0] C_MULHU  = 3'b011;
  localparam logic [2:0] C_DIV    = 3'b100;
  localparam logic [2:0] C_DIVU   = 3'b101;
  localparam logic [2:0] C_REM    = 3'b110;
  localparam logic [2:0] C_REMU   = 3'b111;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [5:0]        r_cnt;
  logic [2:0]        r_op;
  logic [4:0]        r_rd;
  logic              r_neg;     // final result must be negated
  logic              r_bzero;   // divisor was zero
  logic              r_ovf;     // signed INT_MIN / -1
  logic [XLEN-1:0]   r_a;       // raw rs1, returned by REM/REMU on divide-by-zero
  logic [XLEN-1:0]   r_mb;      // |b| (multiplicand or divisor)
  logic [2*XLEN-1:0] r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_wa;

  // --------------------------------------------------------------------------
  // Accept-time decode
  // --------------------------------------------------------------------------
  logic            w_accept;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_res_neg;
  logic            w_bzero;
  logic            w_ovf;

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.flush;

  // Operand signedness, magnitudes and result sign for the requested op
  always_comb begin
    w_sgn_a = 1'b0;
    w_sgn_b = 1'b0;
    case (bus.funct3)
      C_MUL, C_MULH, C_DIV, C_REM: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b1;
      end
      C_MULHSU: begin
        w_sgn_a = 1'b1;
        w_sgn_b = 1'b0;
      end
      default: begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
      end
    endcase

    w_neg_a = w_sgn_a && bus.a[XLEN-1];
    w_neg_b = w_sgn_b && bus.b[XLEN-1];
    w_mag_a = w_neg_a ? (~bus.a + 1'b1) : bus.a;
    w_mag_b = w_neg_b ? (~bus.b + 1'b1) : bus.b;

    // A remainder takes the dividend's sign; everything else takes the
    // product/quotient sign.
    if (bus.funct3 == C_REM) begin
      w_res_neg = w_neg_a;
    end else begin
      w_res_neg = w_neg_a ^ w_neg_b;
    end

    w_bzero = (bus.b == '0);
    w_ovf   = ((bus.funct3 == C_DIV) || (bus.funct3 == C_REM)) &&
              (bus.a == C_INT_MIN) && (bus.b == C_ALL_ONES);
  end

  // --------------------------------------------------------------------------
  // One iteration step
  // --------------------------------------------------------------------------
  logic [XLEN:0]     w_add;     // partial product + multiplicand, with carry
  logic [XLEN:0]     w_hi;      // remainder shifted left with next dividend bit
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;
  logic [2*XLEN-1:0] w_acc_nxt;

  // Shift-add multiply or restoring divide step on the shared accumulator
  always_comb begin
    w_add = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mb};
    w_hi  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_ge  = (w_hi >= {1'b0, r_mb});
    // When w_ge holds the difference is below 2^XLEN, so truncation is exact
    w_sub = w_hi[XLEN-1:0] - r_mb;

    if (r_op[2]) begin
      if (w_ge) begin
        w_acc_nxt = {w_sub, r_acc[XLEN-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_hi[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end
    end else begin
      if (r_acc[0]) begin
        w_acc_nxt = {w_add, r_acc[XLEN-1:1]};
      end else begin
        w_acc_nxt = {1'b0, r_acc[2*XLEN-1:1]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Final result from the last iteration's accumulator
  // --------------------------------------------------------------------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_result;

  // Sign-correct the magnitudes and apply the divide special cases
  always_comb begin
    w_prod = r_neg ? (~w_acc_nxt + 1'b1) : w_acc_nxt;
    w_quot = r_neg ? (~w_acc_nxt[XLEN-1:0] + 1'b1) : w_acc_nxt[XLEN-1:0];
    w_rem  = r_neg ? (~w_acc_nxt[2*XLEN-1:XLEN] + 1'b1) : w_acc_nxt[2*XLEN-1:XLEN];

    case (r_op)
      C_MUL: begin
        w_result = w_prod[XLEN-1:0];
      end
      C_MULH, C_MULHSU, C_MULHU: begin
        w_result = w_prod[2*XLEN-1:XLEN];
      end
      C_DIV, C_DIVU: begin
        if (r_bzero) begin
          w_result = C_ALL_ONES;
        end else if (r_ovf) begin
          w_result = C_INT_MIN;
        end else begin
          w_result = w_quot;
        end
      end
      C_REM, C_REMU: begin
        if (r_bzero) begin
          w_result = r_a;
        end else if (r_ovf) begin
          w_result = '0;
        end else begin
          w_result = w_rem;
        end
      end
      default: begin
        w_result = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: flush wins over everything, DONE always lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == C_LAST_ITER) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    bus.busy = (r_state != S_IDLE);
    bus.done = (r_state == S_DONE);
    bus.we   = (r_state == S_DONE) && (r_wa != 5'd0);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // Capture operands on accept, iterate in CALC, register result on the last step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_bzero  <= 1'b0;
      r_ovf    <= 1'b0;
      r_a      <= '0;
      r_mb     <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_wa     <= '0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_op    <= bus.funct3;
      r_rd    <= bus.rd;
      r_neg   <= w_res_neg;
      r_bzero <= w_bzero;
      r_ovf   <= w_ovf;
      r_a     <= bus.a;
      r_mb    <= w_mag_b;
      r_acc   <= {{XLEN{1'b0}}, w_mag_a};
    end else if ((r_state == S_CALC) && !bus.flush) begin
      r_cnt <= r_cnt + 6'd1;
      r_acc <= w_acc_nxt;
      if (r_cnt == C_LAST_ITER) begin
        r_result <= w_result;
        r_wa     <= r_rd;
      end
    end
  end

  assign bus.result = r_result;
  assign bus.wa     = r_wa;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iterative.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_iterative
//  Purpose  : Scoreboard bench for mdu_iterative: expected results are queued
//             at issue and compared when done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mdu_iterative;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(32)) bus ();

  mdu_iterative #(.XLEN(32)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc      = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent RV32M reference using native wide arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] ub;
    logic signed [31:0] a32;
    logic signed [31:0] b32;
    logic        [63:0] p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ub  = {32'd0, b};
    a32 = a;
    b32 = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return a32 / b32;
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return a32 % b32;
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Result monitor: every done must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.tag, "_result"},  bus.result,          e.res);
        check({e.tag, "_wa"},      {27'd0, bus.wa},     {27'd0, e.rd});
        check({e.tag, "_we"},      {31'd0, bus.we},     {31'd0, (e.rd != 5'd0)});
        check({e.tag, "_latency"}, cyc,                 e.cyc);
      end
    end
    if (reset_n === 1'b1 && bus.done !== 1'b1 && bus.we !== 1'b0) begin
      check("we_without_done", {31'd0, bus.we}, 32'd0);
    end
  end

  // Returns at the first falling edge where the unit is idle
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_idle_timeout", {31'd0, bus.busy}, 32'd0);
  endtask

  // Drive one request; operands are scrambled right after the accept edge
  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input bit track, input bit hold);
    wait_idle();
    bus.funct3 = f;
    bus.a      = a;
    bus.b      = b;
    bus.rd     = rd;
    bus.start  = 1'b1;
    // accept at the next rising edge, done visible 32 edges later
    if (track) sb_q.push_back('{tag, exp, rd, cyc + 33});
    @(posedge clk);
    #1;
    bus.start  = hold;
    bus.a      = $urandom;
    bus.b      = $urandom;
    bus.rd     = 5'($urandom);
    bus.funct3 = 3'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rf;
    int          n;

    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'd0;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    bus.rd     = 5'd0;

    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_done",   {31'd0, bus.done}, 32'd0);
    check("rst_we",     {31'd0, bus.we},   32'd0);
    check("rst_result", bus.result,        32'd0);
    check("rst_wa",     {27'd0, bus.wa},   32'd0);
    reset_n = 1'b1;

    // Directed multiply / divide / special cases
    issue("mul",     3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1, 1'b0);
    issue("mulhu",   3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b1, 1'b0);
    issue("mulh",    3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1'b1, 1'b0);
    issue("mulhsu",  3'b010, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b1, 1'b0);
    issue("div",     3'b100, 32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 1'b1, 1'b0);
    issue("rem",     3'b110, 32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue("divu",    3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        1'b1, 1'b0);
    issue("remu",    3'b111, 32'd100,        32'd7,         5'd12, 32'd2,         1'b1, 1'b0);

    // result must persist after done falls
    wait_idle();
    check("stale_result", bus.result,        32'd2);
    check("idle_done",    {31'd0, bus.done}, 32'd0);

    issue("divu_by0", 3'b101, 32'd5,         32'd0,         5'd13, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue("rem_by0",  3'b110, 32'd5,         32'd0,         5'd14, 32'd5,         1'b1, 1'b0);
    issue("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b1, 1'b0);
    issue("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b1, 1'b0);
    issue("x0",       3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        1'b1, 1'b0);

    // Random operands against the reference model, every funct3
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      rf = 3'(i);
      issue("rand", rf, ra, rb, 5'($urandom_range(1, 31)), ref_mdu(rf, ra, rb), 1'b1, 1'b0);
    end

    // start held high across three back-to-back ops
    issue("held0", 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, ref_mdu(3'b011, 32'h1234_5678, 32'h9ABC_DEF0), 1'b1, 1'b1);
    issue("held1", 3'b100, 32'hFFFF_FF00, 32'd16,        5'd21, 32'hFFFF_FFF0, 1'b1, 1'b1);
    issue("held2", 3'b111, 32'd1000,      32'd33,        5'd22, 32'd10,        1'b1, 1'b0);

    // start pulses while busy must not launch extra operations
    issue("pulse", 3'b000, 32'd100, 32'd200, 5'd23, 32'd20000, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end

    // Flush mid-calculation, then a normal op right after
    issue("flushed", 3'b101, 32'd500, 32'd3, 5'd24, 32'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_done", {31'd0, bus.done}, 32'd0);
    check("flush_we",   {31'd0, bus.we},   32'd0);
    issue("post_flush", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd25, 32'hFFFF_FFFD, 1'b1, 1'b0);

    // flush together with start in IDLE: nothing accepted
    wait_idle();
    bus.funct3 = 3'b000;
    bus.a      = 32'd9;
    bus.b      = 32'd9;
    bus.rd     = 5'd26;
    bus.start  = 1'b1;
    bus.flush  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, bus.busy}, 32'd0);

    // Asynchronous reset mid-calculation
    issue("reset_op", 3'b000, 32'd2, 32'd3, 5'd27, 32'd6, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, bus.busy}, 32'd0);
    check("arst_done",   {31'd0, bus.done}, 32'd0);
    check("arst_we",     {31'd0, bus.we},   32'd0);
    check("arst_result", bus.result,        32'd0);
    check("arst_wa",     {27'd0, bus.wa},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    issue("post_reset", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd28, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Drain the scoreboard
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
